lift53_row_engine: RTL
======================

Name: lift53_row_engine

Overview:
- Parametrised successor to the fixed 26-bit, 128-entry single lifting-step block.
- Accepts one image row of up to 2^ADDR_W samples on a valid/ready stream and buffers it internally.
- Runs both 5/3 lifting steps (predict, update) in forward or inverse mode, with symmetric boundary extension.
- Streams the transformed row out in interleaved order: even index = s/low, odd index = d/high.

Parameters:
- WIDTH, 26: sample width, two's complement.
- ADDR_W, 7: buffer address width; maximum row length is 2^ADDR_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse; starts a row (sampled only in IDLE).
- inverse  in  1  0 = forward, 1 = inverse; latched on start.
- row_len  in  ADDR_W+1  row length N; latched on start.
- in_valid  in  1  input sample valid.
- in_data  in  WIDTH  input sample.
- in_ready  out  1  engine accepts input.
- out_valid  out  1  output sample valid.
- out_data  out  WIDTH  output sample.
- out_ready  in  1  downstream accepts output.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output handshake.
- err  out  1  one-cycle pulse when start carries an illegal row_len.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; in_ready, out_valid, busy, done, err = 0; out_data = 0; buffer contents don't care. Reset mid-row abandons the row.
- States: IDLE -> LOAD -> STEP1 -> STEP2 -> DRAIN -> IDLE.
- IDLE:
  - start with N even and 2 <= N <= 2^ADDR_W: latch inverse and N, go to LOAD.
  - start with any other N: err = 1 for one cycle, stay IDLE.
- LOAD:
  - in_ready = 1. Each in_valid & in_ready stores x[k], k = 0..N-1.
  - After the N-th handshake, in_ready drops the next cycle; go to STEP1.
  - in_valid in any other state is ignored.
- Forward mode:
  - STEP1 (predict): d[i] = x[2i+1] - floor((x[2i] + x[2i+2]) / 2), with x[N] := x[N-2].
  - STEP2 (update): s[i] = x[2i] + floor((d[i-1] + d[i] + 2) / 4), with d[-1] := d[0].
- Inverse mode:
  - STEP1: x[2i] = s[i] - floor((d[i-1] + d[i] + 2) / 4), with d[-1] := d[0].
  - STEP2: x[2i+1] = d[i] + floor((x[2i] + x[2i+2]) / 2), with x[N] := x[N-2].
- STEP1/STEP2 sequencing: in place in the buffer, i = 0..N/2-1. Each element takes 3 clocks (two neighbour reads, then target read and write).
- Arithmetic:
  - Neighbour sum in WIDTH+2 bits; floor is an arithmetic right shift.
  - The final add/sub is truncated (wraps) to WIDTH bits.
- Latency: first out_valid no later than 3*N + 4 cycles after the last input handshake.
- DRAIN:
  - Outputs buffer[0..N-1] in index order.
  - out_data is held stable while out_valid & !out_ready.
  - One sample per cycle when out_ready stays high.
  - After the last handshake: done = 1 for one cycle, busy = 0, return to IDLE.
  - start arriving in the same cycle as done is ignored.
- start while busy is ignored; err is not raised.
- N = 2 is legal: both mirrors collapse onto index 0.

Optional Feature:
- Macro: LIFT53_SAT_EN.
- Defined: every STEP1/STEP2 result saturates to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1] instead of wrapping.
- Not defined: results wrap modulo 2^WIDTH, and no saturation logic is built.

Test Plan:
- Forward, N=4, x=[10,20,30,40], out_ready=1 -> out=[10,0,33,10], then done pulse; busy high from start to done.
- Inverse, N=4, in=[10,0,33,10] -> out=[10,20,30,40] (perfect reconstruction).
- Forward, N=2, x=[-5,4] -> out=[0,9].
- Wrap vs saturate, WIDTH=26, N=2, forward, x=[-33554432, 33554431]:
  - Macro undefined -> out=[-33554432, -1].
  - LIFT53_SAT_EN defined -> out=[-16777216, 33554431].
- Backpressure: N=4 forward with out_ready toggled 1,0,0,1,... -> each out_data held while stalled; exactly 4 handshakes, same values as the first scenario.
- Control faults:
  - start with row_len=5 -> err=1 for one cycle; in_ready stays 0; state stays IDLE.
  - rst_n=0 during STEP1 -> next cycle all outputs 0, IDLE; a following legal row processes correctly.

Source files
------------

// File: rtl/lift53_row_engine.sv
// Row-buffered 5/3 lifting engine: loads a row, runs predict/update in place, streams it out interleaved.
// Optional macro LIFT53_SAT_EN: saturate lifting results instead of wrapping.
module lift53_row_engine #(
    parameter int WIDTH  = 26,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              inverse,
    input  logic [ADDR_W:0]   row_len,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int SW = WIDTH + 2;
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] NMAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, STEP1, STEP2, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W:0]           n_q, n_d, cnt_q, cnt_d;
    logic [1:0]                ph_q, ph_d;
    logic                      inv_q, inv_d, done_q, done_d, err_q, err_d;
    logic signed [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]          mem_q [2**ADDR_W];

    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_wa;
    logic [WIDTH-1:0]          mem_wd;

    logic                      odd_tgt, legal;
    logic [ADDR_W:0]           two_i, addr_a, addr_b, addr_t;
    logic signed [SW-1:0]      nsum, nterm, tgt_ext, res_wide;
    logic [WIDTH-1:0]          res;
    logic                      unused_hi;

    assign legal = !row_len[0] && (row_len >= TWO) && (row_len <= NMAX);

    // Odd targets take the halved even-neighbour sum, even targets the rounded quarter of odd neighbours.
    always_comb begin
        two_i   = {cnt_q[ADDR_W-1:0], 1'b0};
        odd_tgt = (state_q == STEP1) ^ inv_q;
        if (odd_tgt) begin
            addr_a = two_i;
            addr_b = (two_i + TWO == n_q) ? n_q - TWO : two_i + TWO;
            addr_t = two_i + ONE;
        end else begin
            addr_a = (cnt_q == '0) ? ONE : two_i - ONE;
            addr_b = two_i + ONE;
            addr_t = two_i;
        end
    end

    always_comb begin
        nsum    = {{2{a_q[WIDTH-1]}}, a_q} + {{2{b_q[WIDTH-1]}}, b_q}
                + (odd_tgt ? SW'(0) : SW'(2));
        nterm   = odd_tgt ? (nsum >>> 1) : (nsum >>> 2);
        tgt_ext = {{2{mem_q[addr_t[ADDR_W-1:0]][WIDTH-1]}}, mem_q[addr_t[ADDR_W-1:0]]};
        res_wide = (state_q == STEP1) ? tgt_ext - nterm : tgt_ext + nterm;
`ifdef LIFT53_SAT_EN
        if (res_wide > $signed({3'b000, {(WIDTH-1){1'b1}}}))
            res = {1'b0, {(WIDTH-1){1'b1}}};
        else if (res_wide < $signed({3'b111, {(WIDTH-1){1'b0}}}))
            res = {1'b1, {(WIDTH-1){1'b0}}};
        else
            res = res_wide[WIDTH-1:0];
`else
        res = res_wide[WIDTH-1:0];
`endif
    end

`ifdef LIFT53_SAT_EN
    assign unused_hi = ^{addr_a[ADDR_W], addr_b[ADDR_W], addr_t[ADDR_W]};
`else
    assign unused_hi = ^{addr_a[ADDR_W], addr_b[ADDR_W], addr_t[ADDR_W], res_wide[SW-1:WIDTH]};
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        mem_we  = 1'b0;
        mem_wa  = addr_t[ADDR_W-1:0];
        mem_wd  = res;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the finished row.
                if (start && !done_q) begin
                    if (legal) begin
                        n_d     = row_len;
                        inv_d   = inverse;
                        cnt_d   = '0;
                        ph_d    = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    mem_wa = cnt_q[ADDR_W-1:0];
                    mem_wd = in_data;
                    cnt_d  = cnt_q + ONE;
                    if (cnt_q == n_q - ONE) begin
                        cnt_d   = '0;
                        state_d = STEP1;
                    end
                end
            end
            STEP1, STEP2: begin
                case (ph_q)
                    2'd0: begin
                        a_d  = mem_q[addr_a[ADDR_W-1:0]];
                        ph_d = 2'd1;
                    end
                    2'd1: begin
                        b_d  = mem_q[addr_b[ADDR_W-1:0]];
                        ph_d = 2'd2;
                    end
                    default: begin
                        mem_we = 1'b1;
                        ph_d   = 2'd0;
                        cnt_d  = cnt_q + ONE;
                        if (cnt_q == (n_q >> 1) - ONE) begin
                            cnt_d   = '0;
                            state_d = (state_q == STEP1) ? STEP2 : DRAIN;
                        end
                    end
                endcase
            end
            DRAIN: begin
                if (out_ready) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == n_q - ONE) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we)
            mem_q[mem_wa] <= mem_wd;
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? mem_q[cnt_q[ADDR_W-1:0]] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
endmodule
